// File: rtl/dwt53_lift_line.sv
// dwt53_lift_line: streaming 1-D LeGall 5/3 lifting stage, one pixel in, one (L,H) pair per two pixels.
// Optional DWT53_CLAMP_EN saturates out_l to [0,2^DW-1] and out_h to [-2^(DW-1),2^(DW-1)-1].
module dwt53_lift_line #(
  parameter int DW       = 8,
  parameter int LINE_LEN = 64,
  parameter int OW       = DW + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [OW-1:0] out_l,
  output logic signed [OW-1:0] out_h,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam int PW = $clog2(LINE_LEN);
  localparam int W  = DW + 3;

`ifdef DWT53_CLAMP_EN
  localparam logic signed [W-1:0] LMAX = W'((2 ** DW) - 1);
  localparam logic signed [W-1:0] HMAX = W'((2 ** (DW - 1)) - 1);
  localparam logic signed [W-1:0] HMIN = -W'(2 ** (DW - 1));
`endif

  logic [PW-1:0]        pos_q, pos_d;
  logic [DW-1:0]        e_prev_q, e_prev_d;
  logic [DW-1:0]        o_prev_q, o_prev_d;
  logic signed [DW:0]   d_prev_q, d_prev_d;
  logic signed [OW-1:0] l_q, l_d;
  logic signed [OW-1:0] h_q, h_d;
  logic                 last_q, last_d;
  logic                 valid_q, valid_d;

  logic                acc;
  logic                at_last;
  logic                at_even;
  logic                emit;
  logic signed [W-1:0] x0s, x1s, x2s;
  logic signed [W-1:0] sum02, dw, dpw, tw, sw;
  logic signed [W-1:0] lc, hc;
  logic                unused_msb;

  // Downstream slot frees up either when empty or when being drained now.
  assign in_ready = !valid_q || out_ready;

  // Lifting datapath: pick the three samples, predict d, update s.
  always_comb begin
    acc     = in_valid && in_ready;
    at_last = (pos_q == PW'(LINE_LEN - 1));
    at_even = !pos_q[0] && (pos_q != '0);
    emit    = acc && (at_last || at_even);
    x0s     = {3'b000, e_prev_q};
    x1s     = at_last ? {3'b000, in_data} : {3'b000, o_prev_q};
    x2s     = at_last ? {3'b000, e_prev_q} : {3'b000, in_data};
    sum02   = x0s + x2s;
    dw      = x1s - (sum02 >>> 1);
    // First pair of a line mirrors d[0] into d[-1].
    dpw     = (pos_q == PW'(2)) ? dw : {{2{d_prev_q[DW]}}, d_prev_q};
    tw      = dpw + dw + W'(2);
    sw      = x0s + (tw >>> 2);
`ifdef DWT53_CLAMP_EN
    if (sw < 0)         lc = '0;
    else if (sw > LMAX) lc = LMAX;
    else                lc = sw;
    if (dw < HMIN)      hc = HMIN;
    else if (dw > HMAX) hc = HMAX;
    else                hc = dw;
`else
    lc = sw;
    hc = dw;
`endif
  end

  assign unused_msb = lc[W-1] ^ hc[W-1];

  // Next-state for position, sample history and the output slot.
  always_comb begin
    pos_d    = pos_q;
    e_prev_d = e_prev_q;
    o_prev_d = o_prev_q;
    d_prev_d = d_prev_q;
    l_d      = l_q;
    h_d      = h_q;
    last_d   = last_q;
    valid_d  = valid_q && !out_ready;
    if (acc) begin
      pos_d = at_last ? '0 : pos_q + PW'(1);
      if (!pos_q[0]) e_prev_d = in_data;
      if (pos_q[0] && !at_last) o_prev_d = in_data;
    end
    if (emit) begin
      d_prev_d = dw[DW:0];
      l_d      = lc[OW-1:0];
      h_d      = hc[OW-1:0];
      last_d   = at_last;
      valid_d  = 1'b1;
    end
  end

  // State registers; reset drops any partial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q    <= '0;
      e_prev_q <= '0;
      o_prev_q <= '0;
      d_prev_q <= '0;
      l_q      <= '0;
      h_q      <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      e_prev_q <= e_prev_d;
      o_prev_q <= o_prev_d;
      d_prev_q <= d_prev_d;
      l_q      <= l_d;
      h_q      <= h_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
    end
  end

  assign out_l     = l_q;
  assign out_h     = h_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

endmodule

// File: doc/dwt53_lift_line.md
# dwt53_lift_line

Streaming one-dimensional integer LeGall 5/3 lifting wavelet stage for the image-squash datapath. It accepts one pixel per handshake and emits one (low-pass, high-pass) coefficient pair for every two pixels. Boundaries use whole-sample symmetric extension at both ends of each line. It replaces the fixed 8-bit, free-running lifting pipeline with a parametrised, flow-controlled block that one row or column pass of the 2-D transform instantiates.

## Interface
- `DW`, 8: unsigned input pixel width; legal range 4..16.
- `LINE_LEN`, 64: samples per line; must be even and at least 4.
- `OW`, DW+2: signed coefficient output width; derived, not to be overridden.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input DW: unsigned pixel value.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_ready` output 1: the block accepts `in_data` this cycle.
- `out_l` output OW: signed low-pass coefficient s[n].
- `out_h` output OW: signed high-pass coefficient d[n].
- `out_valid` output 1: the `out_l`/`out_h` pair is valid.
- `out_ready` input 1: the consumer accepts the pair.
- `out_last` output 1: marks the final pair of a line; qualified by `out_valid`.

## Operation
- Transfers:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Position counter `pos` runs 0..LINE_LEN-1, advances on each input transfer, and wraps to 0 after LINE_LEN-1.
- Internal registers:
  - `e_prev`: last even sample.
  - `o_prev`: last odd sample.
  - `d_prev`: d[n-1], signed DW+1 bits.
- Action at each input position:
  - pos = 0: load `e_prev`; no output.
  - pos odd and not LINE_LEN-1: load `o_prev`; no output.
  - pos even and ≥ 2: compute pair n = pos/2-1 with x[2n] = `e_prev`, x[2n+1] = `o_prev`, x[2n+2] = `in_data`. Then load `e_prev` with `in_data`.
  - pos = LINE_LEN-1: compute the final pair with x[2n+1] = `in_data` and x[2n+2] = `e_prev` (symmetric extension). Set `out_last`.
- Arithmetic (full precision, floor division as arithmetic right shift):
  - d[n] = x[2n+1] − ((x[2n] + x[2n+2]) >>> 1).
  - s[n] = x[2n] + ((d[n-1] + d[n] + 2) >>> 2).
  - For n = 0, d[-1] is taken equal to d[0].
  - Both results are sign-extended to OW.
- Range: d spans [−(2^DW−1), 2^DW−1]; s spans [−2^(DW−1), 3·2^(DW−1)]. OW = DW+2 therefore never overflows.
- Output register: single entry, holding `out_l`, `out_h`, `out_last` and `out_valid`.
- Flow control:
  - `in_ready` = !`out_valid` || `out_ready`, combinational.
  - Input is never accepted while an unconsumed pair would be overwritten.
  - An output transfer and a new pair load in the same cycle is legal. `out_valid` then stays 1 and the register takes the new pair.
  - While `out_valid && !out_ready`, `out_l`, `out_h` and `out_last` hold stable.
- Line wrap: `d_prev` is not used across lines. The n = 0 rule is re-applied at each new line.
- Reset (asynchronous, also mid-line):
  - `pos`, `e_prev`, `o_prev`, `d_prev` ← 0.
  - `out_valid`, `out_last` ← 0; `out_l`, `out_h` ← 0.
  - Any partial line is discarded. The next accepted sample is pos 0.

## Timing
- Latency: a pair appears on the outputs the cycle after the input transfer that completes it (pos even ≥ 2, or pos LINE_LEN-1).
- Throughput: one input per cycle sustained while `out_ready` = 1. Pair rate is half the input rate.
- `in_ready` is 1 out of reset. It is the only combinational path (`out_ready` → `in_ready`). Every other output is registered.
- Per line, exactly LINE_LEN/2 pairs are produced. Exactly one of them carries `out_last`.

## Configuration
- `DWT53_CLAMP_EN`:
  - Defined: saturate registered outputs. `out_l` is clamped to [0, 2^DW−1] and `out_h` to [−2^(DW−1), 2^(DW−1)−1], still presented sign-extended at OW bits. The internal `d_prev` keeps the unclamped d.
  - Undefined: outputs are the full-precision values with no saturation logic.

## Test plan
- DW=8, LINE_LEN=8, inputs 145,56,49,89,137,90,62,33, `out_ready`=1 -> pairs (L,H) = (125,−41), (38,−4), (134,−9), (53,−29); `out_last` set on the 4th pair only.
- Constant input 100 for two lines -> 8 pairs of (100,0); `out_last` on pairs 4 and 8.
- Same data as the first scenario with `out_ready` low for 3 cycles while `out_valid`=1 -> `in_ready`=0 for those cycles, the held pair is stable, and the final sequence is identical.
- LINE_LEN=4, inputs 0,255,0,255 -> (128,255),(128,255) without clamp; with `DWT53_CLAMP_EN`, (128,127),(128,127).
- `rst` pulsed after 5 samples of a line, then the first-scenario line is sent -> no stray pair, outputs 0 during reset, and the full expected sequence follows.
- Random `in_valid`/`out_ready` over 1000 random 8-bit samples -> every pair matches the reference model; no loss or duplication.
